ccd_pixel_packer: RTL and testbench

Sits between the CCD readout sampler and the TX FIFO write port. Assembles the AD9826 8-bit output stream (high byte then low byte per pixel) into 16-bit pixels and buffers them in a small internal FIFO. Frames them into a byte stream with frame/line headers and writes it to the TX FIFO using its `wfull` back-pressure.

---
 rtl/ccd_pixel_packer_if.sv | 21 ++
 rtl/ccd_pixel_packer.sv | 188 ++++++++++++++++++
 tb/tb_ccd_pixel_packer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_pixel_packer_if.sv
// Byte-side handshake between the CCD sampler, the pixel packer and the TX FIFO write port.
interface ccd_pixel_packer_if;
  logic       frame_start;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       wfull;
  logic [7:0] wdata;
  logic       winc;
  logic       busy;
  logic       overflow;

  modport master (
    output frame_start, byte_valid, byte_in, wfull,
    input  wdata, winc, busy, overflow
  );

  modport slave (
    input  frame_start, byte_valid, byte_in, wfull,
    output wdata, winc, busy, overflow
  );
endinterface

// File: rtl/ccd_pixel_packer.sv
// Pairs AD9826 bytes into 16-bit pixels, buffers them, and frames them into a
// header/line-numbered byte stream for the TX FIFO write port.
module ccd_pixel_packer #(
  parameter int PIXELS_PER_LINE = 800,
  parameter int LINES_PER_FRAME = 520,
  parameter int BUF_LOG2        = 4
) (
  input  logic              clk,
  input  logic              rst,
  ccd_pixel_packer_if.slave bus
);
  localparam int          DEPTH     = 1 << BUF_LOG2;
  localparam logic [15:0] PIX_LAST  = 16'(PIXELS_PER_LINE - 1);
  localparam logic [15:0] LINE_LAST = 16'(LINES_PER_FRAME - 1);
  localparam logic [16:0] LINES     = 17'(LINES_PER_FRAME);

  typedef enum logic [2:0] {
    IDLE, FHDR, LHDR, LNUM_HI, LNUM_LO, PIX_HI, PIX_LO, FEND
  } state_t;

  // The input line tag lets the output side notice a line cut short by drops.
  typedef struct packed {
    logic        eol;
    logic [15:0] line;
    logic [15:0] data;
  } entry_t;

  state_t            r_state;
  entry_t            r_mem [DEPTH];
  logic [BUF_LOG2:0] r_wptr;
  logic [BUF_LOG2:0] r_rptr;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [15:0]       r_in_pix;
  logic [16:0]       r_in_line;
  logic [15:0]       r_out_line;
  logic              r_busy;
  logic              r_overflow;

  entry_t     w_head;
  logic       w_empty;
  logic       w_full;
  logic       w_head_ok;
  logic       w_line_cut;
  logic       w_last_line;
  logic       w_in_done;
  logic       w_accept;
  logic       w_push_req;
  logic       w_push;
  logic       w_drop;
  logic       w_pop;
  logic       w_emit;
  logic       w_winc;
  logic [7:0] w_wdata;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[BUF_LOG2] != r_rptr[BUF_LOG2]) &&
                       (r_wptr[BUF_LOG2-1:0] == r_rptr[BUF_LOG2-1:0]);
  assign w_head      = r_mem[r_rptr[BUF_LOG2-1:0]];
  assign w_head_ok   = !w_empty && (w_head.line == r_out_line);
  assign w_line_cut  = w_empty ? (r_in_line > {1'b0, r_out_line})
                               : (w_head.line != r_out_line);
  assign w_last_line = (r_out_line == LINE_LAST);
  assign w_in_done   = (r_in_line == LINES);
  assign w_accept    = bus.byte_valid && r_busy && !w_in_done && !bus.frame_start;
  assign w_push_req  = w_accept && r_phase;
  assign w_winc      = w_emit && !bus.wfull;
  assign w_pop       = w_winc && (r_state == PIX_LO);
  // A same-cycle pop frees the slot, so a push into a full buffer still lands.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && !w_push;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_emit  = 1'b0;
    w_wdata = 8'h00;
    case (r_state)
      FHDR:    begin w_emit = 1'b1; w_wdata = 8'hF5;              end
      LHDR:    begin w_emit = 1'b1; w_wdata = 8'hA5;              end
      LNUM_HI: begin w_emit = 1'b1; w_wdata = r_out_line[15:8];   end
      LNUM_LO: begin w_emit = 1'b1; w_wdata = r_out_line[7:0];    end
      PIX_HI:  begin
        w_emit  = w_head_ok;
        w_wdata = w_head_ok ? w_head.data[15:8] : 8'h00;
      end
      PIX_LO:  begin
        w_emit  = w_head_ok;
        w_wdata = w_head_ok ? w_head.data[7:0] : 8'h00;
      end
      FEND:    begin w_emit = 1'b1; w_wdata = 8'hFE;              end
      default: ;
    endcase
  end

  assign bus.winc     = w_winc;
  assign bus.wdata    = w_wdata;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

  // NOTE: the storage array has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[BUF_LOG2-1:0]] <= '{eol:  (r_in_pix == PIX_LAST),
                                       line: r_in_line[15:0],
                                       data: {r_hi, bus.byte_in}};
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_phase    <= 1'b0;
      r_hi       <= 8'h00;
      r_in_pix   <= '0;
      r_in_line  <= '0;
      r_out_line <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.frame_start) begin
      r_state    <= FHDR;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_phase    <= 1'b0;
      r_in_pix   <= '0;
      r_in_line  <= '0;
      r_out_line <= '0;
      r_busy     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_phase <= !r_phase;
        if (!r_phase) begin
          r_hi <= bus.byte_in;
        end else if (r_in_pix == PIX_LAST) begin
          r_in_pix  <= '0;
          r_in_line <= r_in_line + 17'd1;
        end else begin
          r_in_pix <= r_in_pix + 16'd1;
        end
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        FHDR:    if (w_winc) r_state <= LHDR;
        LHDR:    if (w_winc) r_state <= LNUM_HI;
        LNUM_HI: if (w_winc) r_state <= LNUM_LO;
        LNUM_LO: if (w_winc) r_state <= PIX_HI;
        PIX_HI: begin
          if (w_winc) begin
            r_state <= PIX_LO;
          end else if (w_line_cut) begin
            // Remaining pixels of this line were dropped; close it at the input boundary.
            if (w_last_line) begin
              r_state <= FEND;
            end else begin
              r_state    <= LHDR;
              r_out_line <= r_out_line + 16'd1;
            end
          end
        end
        PIX_LO: begin
          if (w_winc) begin
            if (!w_head.eol) begin
              r_state <= PIX_HI;
            end else if (w_last_line) begin
              r_state <= FEND;
            end else begin
              r_state    <= LHDR;
              r_out_line <= r_out_line + 16'd1;
            end
          end
        end
        FEND: begin
          if (w_winc) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Directed bench for ccd_pixel_packer: a 4x2 instance for framing, stalls, idle bytes
// and reset, plus an 8x2 instance with a 4-pixel buffer for overflow and abort.
module tb_ccd_pixel_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccd_pixel_packer_if pa ();
  ccd_pixel_packer_if pb ();

  ccd_pixel_packer #(.PIXELS_PER_LINE(4), .LINES_PER_FRAME(2), .BUF_LOG2(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (pa)
  );

  ccd_pixel_packer #(.PIXELS_PER_LINE(8), .LINES_PER_FRAME(2), .BUF_LOG2(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (pb)
  );

  int         total = 0;
  int         bad   = 0;
  int         viol  = 0;
  bit         rand_a = 1'b0;
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  logic [7:0] exp_q [$];

  // Byte capture: a write happens at the next edge whenever winc is high mid-cycle.
  always @(negedge clk) begin
    if (pa.winc === 1'b1) cap_a.push_back(pa.wdata);
    if (pb.winc === 1'b1) cap_b.push_back(pb.wdata);
    if ((pa.winc === 1'b1 && pa.wfull === 1'b1) || (pb.winc === 1'b1 && pb.wfull === 1'b1)) viol++;
  end

  always @(posedge clk) begin
    if (rand_a) begin
      #1;
      pa.wfull = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit cond(input int sel, input int n);
    case (sel)
      0:       return pa.busy === 1'b0;
      1:       return cap_a.size() >= n;
      2:       return pb.busy === 1'b0;
      default: return cap_b.size() >= n;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while (!cond(sel, n) && k < budget) begin
      step();
      k++;
    end
    check({tag, ".wait"}, 32'(cond(sel, n)), 32'd1);
  endtask

  task automatic send(input int sel, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        pa.byte_valid = 1'b1;
        pa.byte_in    = first + 8'(i);
      end else begin
        pb.byte_valid = 1'b1;
        pb.byte_in    = first + 8'(i);
      end
      step();
    end
    pa.byte_valid = 1'b0;
    pb.byte_valid = 1'b0;
  endtask

  task automatic pulse(input int sel);
    if (sel == 0) pa.frame_start = 1'b1;
    else          pb.frame_start = 1'b1;
    step();
    pa.frame_start = 1'b0;
    pb.frame_start = 1'b0;
  endtask

  task automatic cmp_stream(input int sel, input string tag);
    logic [7:0] got [$];
    if (sel == 0) got = cap_a;
    else          got = cap_b;
    check({tag, ".len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic push_hdr(input logic [7:0] line);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(line);
  endtask

  task automatic push_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
  endtask

  initial begin
    rst = 1'b1;
    pa.frame_start = 1'b0; pa.byte_valid = 1'b0; pa.byte_in = 8'h00; pa.wfull = 1'b0;
    pb.frame_start = 1'b0; pb.byte_valid = 1'b0; pb.byte_in = 8'h00; pb.wfull = 1'b0;
    step();
    step();
    check("a_rst_winc", 32'(pa.winc), 32'd0);
    check("a_rst_wdata", 32'(pa.wdata), 32'd0);
    check("a_rst_busy", 32'(pa.busy), 32'd0);
    check("a_rst_ovf", 32'(pa.overflow), 32'd0);
    check("b_rst_winc", 32'(pb.winc), 32'd0);
    check("b_rst_busy", 32'(pb.busy), 32'd0);
    rst = 1'b0;
    step();

    // Plain 4x2 frame; the two trailing bytes land after the last pixel and must be ignored.
    pulse(0);
    check("a_busy_rise", 32'(pa.busy), 32'd1);
    send(0, 8'h01, 18);
    wait_for(0, 0, 200, "a_frame1_idle");
    exp_q.delete();
    exp_q.push_back(8'hF5);
    push_hdr(8'h00); push_run(8'h01, 8);
    push_hdr(8'h01); push_run(8'h09, 8);
    exp_q.push_back(8'hFE);
    cmp_stream(0, "a_frame1");
    check("a_frame1_ovf", 32'(pa.overflow), 32'd0);
    check("a_frame1_phase", 32'(u_dut_a.r_phase), 32'd0);

    // Same frame under random back-pressure: identical byte sequence expected.
    cap_a.delete();
    rand_a = 1'b1;
    pulse(0);
    send(0, 8'h01, 16);
    wait_for(0, 0, 600, "a_frame2_idle");
    rand_a = 1'b0;
    step();
    pa.wfull = 1'b0;
    cmp_stream(0, "a_frame2");
    check("a_frame2_ovf", 32'(pa.overflow), 32'd0);
    check("winc_while_full", 32'(viol), 32'd0);

    // Bytes while idle are ignored.
    cap_a.delete();
    send(0, 8'hAA, 3);
    repeat (3) step();
    check("a_idle_nowrite", 32'(cap_a.size()), 32'd0);
    check("a_idle_phase", 32'(u_dut_a.r_phase), 32'd0);
    check("a_idle_busy", 32'(pa.busy), 32'd0);

    // Overflow: output stalled 40 cycles while all of line 0 arrives into a 4-pixel buffer.
    pb.wfull = 1'b1;
    pulse(1);
    send(1, 8'h11, 16);
    repeat (23) step();
    check("b_ovf_set", 32'(pb.overflow), 32'd1);
    check("b_stall_nowrite", 32'(cap_b.size()), 32'd0);
    pb.wfull = 1'b0;
    wait_for(3, 15, 100, "b_line1_hdr");
    send(1, 8'h21, 16);
    wait_for(2, 0, 200, "b_frame1_idle");
    exp_q.delete();
    exp_q.push_back(8'hF5);
    push_hdr(8'h00); push_run(8'h11, 8);
    push_hdr(8'h01); push_run(8'h21, 16);
    exp_q.push_back(8'hFE);
    cmp_stream(1, "b_frame1");
    check("b_ovf_sticky", 32'(pb.overflow), 32'd1);

    // frame_start from idle clears overflow; then overflow again and abort mid-line 1.
    cap_b.delete();
    pb.wfull = 1'b1;
    pulse(1);
    check("b_ovf_clr_idle", 32'(pb.overflow), 32'd0);
    send(1, 8'h31, 16);
    step();
    check("b_ovf_set2", 32'(pb.overflow), 32'd1);
    pb.wfull = 1'b0;
    wait_for(3, 15, 100, "b_f2_line1_hdr");
    send(1, 8'h41, 4);
    wait_for(3, 19, 100, "b_f2_mid_line1");
    repeat (4) step();
    exp_q.delete();
    exp_q.push_back(8'hF5);
    push_hdr(8'h00); push_run(8'h31, 8);
    push_hdr(8'h01); push_run(8'h41, 4);
    cmp_stream(1, "b_pre_abort");

    pb.wfull       = 1'b1;
    pb.frame_start = 1'b1;
    pb.byte_valid  = 1'b1;
    pb.byte_in     = 8'h99;
    step();
    pb.frame_start = 1'b0;
    pb.byte_valid  = 1'b0;
    check("b_abort_ovf", 32'(pb.overflow), 32'd0);
    check("b_abort_busy", 32'(pb.busy), 32'd1);
    check("b_abort_phase", 32'(u_dut_b.r_phase), 32'd0);
    cap_b.delete();
    pb.wfull = 1'b0;
    wait_for(3, 4, 50, "b_restart");
    repeat (3) step();
    exp_q.delete();
    exp_q.push_back(8'hF5);
    push_hdr(8'h00);
    cmp_stream(1, "b_restart");

    // Reset while stalled in PIX_LO with one pixel still buffered.
    cap_a.delete();
    pulse(0);
    send(0, 8'h51, 2);
    wait_for(1, 5, 50, "a_pix_hi");
    pa.wfull = 1'b1;
    #1;
    check("a_stall_winc", 32'(pa.winc), 32'd0);
    rst = 1'b1;
    step();
    check("a_rst2_winc", 32'(pa.winc), 32'd0);
    check("a_rst2_wdata", 32'(pa.wdata), 32'd0);
    check("a_rst2_busy", 32'(pa.busy), 32'd0);
    check("a_rst2_ovf", 32'(pa.overflow), 32'd0);
    check("a_rst2_empty", 32'(u_dut_a.w_empty), 32'd1);
    check("a_rst2_phase", 32'(u_dut_a.r_phase), 32'd0);
    check("a_rst2_nolo", 32'(cap_a.size()), 32'd5);
    rst = 1'b0;
    pa.wfull = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
